seg7_readback: RTL and testbench

- Loopback checker for the two-digit seven-segment display path; decodes the driven patterns back to a binary value.
- Sits beside `display`, taps `first7S` (tens) and `second7S` (units), and reports the shown value only once it is stable.
- Reports illegal patterns on a sticky error flag.
- Used in self-check benches and on-board diagnostics of the vending machine front panel.

---
 rtl/seg7_readback.sv | 163 ++++++++++++++++
 tb/tb_seg7_readback.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seg7_readback.sv
// seg7_readback: loopback checker for the two-digit seven-segment display.
// Samples the tens/units segment buses and waits for a run of identical
// samples. It then decodes the pair back to a binary value 0..99 and
// reports patterns that no digit can produce.
// Optional build macro: SEG7_ACTIVE_LOW_EN (common-anode panel, 0 = lit).
module seg7_readback #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] first7S,
  input  logic [6:0] second7S,
  output logic [6:0] data_out,
  output logic       data_valid,
  output logic       locked,
  output logic       blank,
  output logic       seg_err
);

  localparam logic [2:0] ST_SETTLE = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_LOCKED = 3'd2;
  localparam logic [2:0] ST_BLANK  = 3'd3;
  localparam logic [2:0] ST_BAD    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef SEG7_ACTIVE_LOW_EN
  // Raw pins are active-low, so the dark reset sample is all ones. Decoding
  // works on the inverted value.
  localparam logic [13:0] SAMPLE_RST = 14'h3FFF;
  localparam logic [13:0] INV_MASK   = 14'h3FFF;
`else
  localparam logic [13:0] SAMPLE_RST = 14'h0000;
  localparam logic [13:0] INV_MASK   = 14'h0000;
`endif

  // Map one digit pattern to {legal, digit}. Only exact table matches are legal.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h3F:   res = 5'b1_0000;
      7'h06:   res = 5'b1_0001;
      7'h5B:   res = 5'b1_0010;
      7'h4F:   res = 5'b1_0011;
      7'h66:   res = 5'b1_0100;
      7'h6D:   res = 5'b1_0101;
      7'h7D:   res = 5'b1_0110;
      7'h07:   res = 5'b1_0111;
      7'h7F:   res = 5'b1_1000;
      7'h6F:   res = 5'b1_1001;
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  logic [13:0]      r_sample_q;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_state;
  logic [6:0]       r_data_out;
  logic             r_data_valid;
  logic             r_locked;
  logic             r_blank;
  logic             r_seg_err;

  logic [13:0] w_sample_in;
  logic        w_changed;
  logic [13:0] w_pair;
  logic [6:0]  w_tens_seg;
  logic [6:0]  w_units_seg;
  logic [4:0]  w_tens_dec;
  logic [4:0]  w_units_dec;
  logic        w_tens_dark;
  logic        w_units_dark;
  logic        w_both_dark;
  logic        w_pair_good;
  logic [6:0]  w_tens7;
  logic [6:0]  w_value;

  assign w_sample_in = {first7S, second7S};
  assign w_changed   = (w_sample_in != r_sample_q);

  // Decode the held sample. It is the stable pair whenever the FSM is in DECODE.
  always_comb begin
    w_pair       = r_sample_q ^ INV_MASK;
    w_tens_seg   = w_pair[13:7];
    w_units_seg  = w_pair[6:0];
    w_tens_dec   = seg_decode(w_tens_seg);
    w_units_dec  = seg_decode(w_units_seg);
    w_tens_dark  = (w_tens_seg == 7'h00);
    w_units_dark = (w_units_seg == 7'h00);
    w_both_dark  = w_tens_dark & w_units_dark;
    // A dark tens digit is leading-zero blanking and decodes as 0.
    w_pair_good  = (w_tens_dark | w_tens_dec[4]) & w_units_dec[4];
    w_tens7      = {3'b000, w_tens_dec[3:0]};
    // tens*10 = tens*8 + tens*2; the largest result is 99, so it fits in 7 bits.
    w_value      = (w_tens7 << 3) + (w_tens7 << 1) + {3'b000, w_units_dec[3:0]};
  end

  // Sample register, stability counter, FSM and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample_q   <= SAMPLE_RST;
      r_cnt        <= '0;
      r_state      <= ST_SETTLE;
      r_data_out   <= 7'd0;
      r_data_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_blank      <= 1'b0;
      r_seg_err    <= 1'b0;
    end else begin
      r_sample_q   <= w_sample_in;
      r_data_valid <= 1'b0;
      if (w_changed) begin
        // Any change restarts settling, including a change that lands in DECODE.
        r_cnt    <= '0;
        r_state  <= ST_SETTLE;
        r_locked <= 1'b0;
        r_blank  <= 1'b0;
      end else begin
        case (r_state)
          ST_SETTLE: begin
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_DECODE;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
              if (r_cnt == (CNT_LAST - CNT_ONE)) begin
                r_state <= ST_DECODE;
              end
            end
          end
          ST_DECODE: begin
            if (w_both_dark) begin
              r_blank <= 1'b1;
              r_state <= ST_BLANK;
            end else if (w_pair_good) begin
              r_data_out   <= w_value;
              r_data_valid <= 1'b1;
              r_locked     <= 1'b1;
              r_state      <= ST_LOCKED;
            end else begin
              r_seg_err <= 1'b1;
              r_state   <= ST_BAD;
            end
          end
          ST_LOCKED: r_state <= ST_LOCKED;
          ST_BLANK:  r_state <= ST_BLANK;
          ST_BAD:    r_state <= ST_BAD;
          default:   r_state <= ST_SETTLE;
        endcase
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign locked     = r_locked;
  assign blank      = r_blank;
  assign seg_err    = r_seg_err;

endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback (default active-high build, STABLE_CYCLES=4).
module tb_seg7_readback;

  logic       clk;
  logic       rst;
  logic [6:0] first7S;
  logic [6:0] second7S;
  logic [6:0] data_out;
  logic       data_valid;
  logic       locked;
  logic       blank;
  logic       seg_err;

  int n_tests;
  int n_fail;
  int pulses;
  int first_step;

  seg7_readback #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .first7S    (first7S),
    .second7S   (second7S),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .blank      (blank),
    .seg_err    (seg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] f;
    logic [6:0] s;
    int         hold;
    int         exp_pulses;
    int         exp_first;
    logic [6:0] exp_data;
    logic       exp_locked;
    logic       exp_blank;
    logic       exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Present a pair for n edges. Count data_valid pulses and note the step
  // (1-based) at which the first pulse appears.
  task automatic run_pair(input logic [6:0] f, input logic [6:0] s, input int n);
    first7S    = f;
    second7S   = s;
    pulses     = 0;
    first_step = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (data_valid === 1'b1) begin
        pulses++;
        if (first_step == 0) first_step = k;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_out"},   {25'd0, data_out}, 32'd0);
    chk({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
    chk({tag, "_locked"},     {31'd0, locked}, 32'd0);
    chk({tag, "_blank"},      {31'd0, blank}, 32'd0);
    chk({tag, "_seg_err"},    {31'd0, seg_err}, 32'd0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    first7S  = 7'h00;
    second7S = 7'h00;

    //               f      s      hold pul first data  lk    bl    err
    vecs[0]  = '{7'h4F, 7'h66, 8, 1, 5, 7'd34, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{7'h5B, 7'h3F, 2, 0, 0, 7'd34, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{7'h00, 7'h3F, 8, 1, 5, 7'd0,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{7'h00, 7'h00, 6, 0, 0, 7'd0,  1'b0, 1'b1, 1'b0};
    vecs[4]  = '{7'h00, 7'h3F, 8, 1, 5, 7'd0,  1'b1, 1'b0, 1'b0};
    vecs[5]  = '{7'h6F, 7'h6F, 8, 1, 5, 7'd99, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{7'h6F, 7'h07, 8, 1, 5, 7'd97, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{7'h3F, 7'h7E, 6, 0, 0, 7'd97, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{7'h06, 7'h06, 8, 1, 5, 7'd11, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{7'h00, 7'h6D, 8, 1, 5, 7'd5,  1'b1, 1'b0, 1'b1};
    vecs[10] = '{7'h7F, 7'h00, 6, 0, 0, 7'd5,  1'b0, 1'b0, 1'b1};

    // Reset state.
    step();
    step();
    chk_reset_outputs("reset");

    // Dark display after reset: blank appears after the 4th edge, never a pulse.
    rst = 1'b0;
    run_pair(7'h00, 7'h00, 3);
    chk("dark_blank_before_edge4", {31'd0, blank}, 32'd0);
    chk("dark_pulses_3", pulses, 32'd0);
    run_pair(7'h00, 7'h00, 1);
    chk("dark_blank_edge4", {31'd0, blank}, 32'd1);
    run_pair(7'h00, 7'h00, 4);
    chk("dark_pulses", pulses, 32'd0);
    chk("dark_seg_err", {31'd0, seg_err}, 32'd0);
    chk("dark_blank_held", {31'd0, blank}, 32'd1);

    // Main table.
    for (int i = 0; i < 11; i++) begin
      run_pair(vecs[i].f, vecs[i].s, vecs[i].hold);
      chk($sformatf("v%0d_pulses", i), pulses, vecs[i].exp_pulses);
      chk($sformatf("v%0d_first", i), first_step, vecs[i].exp_first);
      chk($sformatf("v%0d_data", i), {25'd0, data_out}, {25'd0, vecs[i].exp_data});
      chk($sformatf("v%0d_locked", i), {31'd0, locked}, {31'd0, vecs[i].exp_locked});
      chk($sformatf("v%0d_blank", i), {31'd0, blank}, {31'd0, vecs[i].exp_blank});
      chk($sformatf("v%0d_err", i), {31'd0, seg_err}, {31'd0, vecs[i].exp_err});
    end

    // Reset while 68 settles at cnt=2; clears the sticky error too.
    run_pair(7'h7D, 7'h7F, 3);
    rst = 1'b1;
    step();
    chk_reset_outputs("midsettle_rst");
    rst = 1'b0;
    run_pair(7'h7D, 7'h7F, 4);
    chk("post_rst_no_early", pulses, 32'd0);
    run_pair(7'h7D, 7'h7F, 1);
    chk("post_rst_pulse", pulses, 32'd1);
    chk("post_rst_data", {25'd0, data_out}, 32'd68);
    chk("post_rst_err", {31'd0, seg_err}, 32'd0);

    // An illegal pair removed while in DECODE: no error, no pulse.
    run_pair(7'h7E, 7'h7E, 4);
    chk("abort_bad_pulses", pulses, 32'd0);
    chk("abort_bad_err", {31'd0, seg_err}, 32'd0);
    // A legal pair removed while in DECODE: no pulse, and data_out keeps 68.
    run_pair(7'h4F, 7'h66, 4);
    chk("abort_good_pulses", pulses, 32'd0);
    run_pair(7'h06, 7'h06, 8);
    chk("abort_next_pulses", pulses, 32'd1);
    chk("abort_next_first", first_step, 32'd5);
    chk("abort_next_data", {25'd0, data_out}, 32'd11);
    chk("abort_next_err", {31'd0, seg_err}, 32'd0);

    // A dark units digit under a lit tens digit is illegal and sets the error.
    run_pair(7'h7F, 7'h00, 6);
    chk("units_dark_err", {31'd0, seg_err}, 32'd1);
    chk("units_dark_data", {25'd0, data_out}, 32'd11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
